pipeline_hazard_ctrl: RTL

//  Stall/flush sequencer for the 5-stage pipeline, sitting beside the forwarding unit.
//  - Detects load-use hazards that forwarding cannot cover and inserts a 1-cycle bubble.
//  - Flushes IF/ID on a taken branch resolved in ID.
//  - Arbitrates the single main-memory port between I-cache and D-cache misses;
//    D-cache has priority. Freezes the pipeline stages while a miss is serviced.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/load_use_detect.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DMISS = 2'd1,
        IMISS = 2'd2
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID-stage read of a register that the load in EX
// has not yet produced and that forwarding cannot supply.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             uses_rt,
    input  logic             is_store,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_wr,
    output logic             lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (id_rs == ex_wr);
    // A store's Rt is picked up later by MEM-to-MEM forwarding, so it never stalls.
    assign rt_hit = (id_rt == ex_wr) && uses_rt && !is_store;
    assign lu     = ex_mem_read && (ex_wr != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flush and memory-port arbitration
// between I- and D-cache misses. Stall counters are built only with HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             ID_IsStore,
    input  logic             ID_BranchTaken,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_WriteRegister,
    input  logic             ICacheMiss,
    input  logic             DCacheMiss,
    input  logic             IMissDone,
    input  logic             DMissDone,
    output logic             IMissGrant,
    output logic             DMissGrant,
    output logic             PC_WE,
    output logic             IF_ID_WE,
    output logic             ID_EX_WE,
    output logic             EX_MEM_WE,
    output logic             MEM_WB_WE,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Flush,
    output logic [CNT_W-1:0] LoadUseCnt,
    output logic [CNT_W-1:0] MissStallCnt
);

    state_t state;
    state_t state_next;
    logic   lu;
    logic   dmiss_act;
    logic   imiss_act;
    logic   lu_stall;

    load_use_detect u_lu (
        .id_rs       (IF_ID_Rs),
        .id_rt       (IF_ID_Rt),
        .uses_rt     (IF_ID_UsesRt),
        .is_store    (ID_IsStore),
        .ex_mem_read (ID_EX_MemRead),
        .ex_wr       (ID_EX_WriteRegister),
        .lu          (lu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (DCacheMiss)      state_next = DMISS;
                else if (ICacheMiss) state_next = IMISS;
            end
            DMISS: if (DMissDone) state_next = ICacheMiss ? IMISS : RUN;
            IMISS: if (IMissDone) state_next = DCacheMiss ? DMISS : RUN;
            default: state_next = RUN;
        endcase
    end

    assign IMissGrant = (state == IMISS);
    assign DMissGrant = (state == DMISS);

    // In RUN a freshly raised miss already stalls the way its target state will.
    assign dmiss_act = (state == DMISS) || ((state == RUN) && DCacheMiss);
    assign imiss_act = (state == IMISS) || ((state == RUN) && !DCacheMiss && ICacheMiss);
    assign lu_stall  = (state == RUN) && !DCacheMiss && !ICacheMiss && lu;

    always_comb begin
        PC_WE        = 1'b1;
        IF_ID_WE     = 1'b1;
        ID_EX_WE     = 1'b1;
        EX_MEM_WE    = 1'b1;
        MEM_WB_WE    = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MEM_WB_Flush = 1'b0;
        if (!rst_n) begin
            PC_WE        = 1'b0;
            IF_ID_WE     = 1'b0;
            ID_EX_WE     = 1'b0;
            EX_MEM_WE    = 1'b0;
            MEM_WB_WE    = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            MEM_WB_Flush = 1'b1;
        end else if (dmiss_act) begin
            PC_WE        = 1'b0;
            IF_ID_WE     = 1'b0;
            ID_EX_WE     = 1'b0;
            EX_MEM_WE    = 1'b0;
            MEM_WB_WE    = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (imiss_act) begin
            PC_WE       = 1'b0;
            IF_ID_Flush = 1'b1;
            if (DCacheMiss) begin
                ID_EX_WE     = 1'b0;
                EX_MEM_WE    = 1'b0;
                MEM_WB_Flush = 1'b1;
            end
        end else if (lu_stall) begin
            PC_WE       = 1'b0;
            IF_ID_WE    = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (ID_BranchTaken) begin
            IF_ID_Flush = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LoadUseCnt   <= '0;
            MissStallCnt <= '0;
        end else begin
            if (lu_stall && (LoadUseCnt != {CNT_W{1'b1}}))
                LoadUseCnt <= LoadUseCnt + 1'b1;
            if ((state != RUN) && (MissStallCnt != {CNT_W{1'b1}}))
                MissStallCnt <= MissStallCnt + 1'b1;
        end
    end
`else
    assign LoadUseCnt   = '0;
    assign MissStallCnt = '0;
`endif

endmodule
